// File: rtl/apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_bridge_pkg
// Description : Shared FSM state type and APB address window for apb_req_bridge.
// Revision    : 1.0
// ============================================================================
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [31:0] APB_WIN_START = 32'h1A10_0000;
    localparam logic [31:0] APB_WIN_END   = 32'h1A11_7FFF;

endpackage
`default_nettype wire

// File: rtl/apb_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : APB_BUS
// Description : APB bus signal bundle with master and slave modports.
// Revision    : 1.0
// ============================================================================
interface APB_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : apb_timeout_cnt
// Description : Counts ACCESS wait cycles; o_last flags the final allowed one.
// Revision    : 1.0
// ============================================================================
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);
    localparam int unsigned             c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]      c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Abort happens in the cycle whose stall would bring the count to the limit
    assign o_last = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/apb_req_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_bridge
// Description : Core-side req/gnt/rvalid port to APB master bridge.
//               Optional ACCESS timeout when APB_BRIDGE_TIMEOUT_EN is defined.
// Revision    : 1.0
// ============================================================================
module apb_req_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic                      data_we_i,
    input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
    output logic                      data_err_o,
    APB_BUS.Master                    apb_master
);
    localparam int unsigned c_cmp_w = (APB_ADDR_WIDTH > 32) ? APB_ADDR_WIDTH : 32;
    localparam logic [c_cmp_w-1:0] c_win_lo = c_cmp_w'(APB_WIN_START);
    localparam logic [c_cmp_w-1:0] c_win_hi = c_cmp_w'(APB_WIN_END);

    if (TIMEOUT_CYCLES == 0) begin : g_timeout_cfg_chk
        $error("apb_req_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_e                r_state;
    apb_state_e                w_state_nxt;
    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic [APB_DATA_WIDTH-1:0] r_wdata;
    logic                      r_we;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_rvalid;
    logic                      r_err;
    logic [APB_DATA_WIDTH-1:0] r_rdata;

    logic                      w_gnt;
    logic                      w_in_win;
    logic                      w_timeout;
    logic                      w_rsp_vld;
    logic                      w_rsp_err;
    logic [APB_DATA_WIDTH-1:0] w_rsp_data;
    logic [c_cmp_w-1:0]        w_addr_ext;

    assign w_addr_ext = c_cmp_w'(data_addr_i);
    assign w_in_win   = (w_addr_ext >= c_win_lo) && (w_addr_ext <= c_win_hi);

`ifdef APB_BRIDGE_TIMEOUT_EN
    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state != ACCESS),
        .i_inc  ((r_state == ACCESS) && !apb_master.pready),
        .o_last (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_gnt       = 1'b0;
        w_state_nxt = r_state;
        w_rsp_vld   = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_data  = '0;
        unique case (r_state)
            IDLE: begin
                w_gnt = data_req_i & ~rst;
                if (w_gnt) begin
                    if (w_in_win) begin
                        w_state_nxt = SETUP;
                    end else begin
                        // Out-of-window: answer with an error, never touch the bus
                        w_rsp_vld = 1'b1;
                        w_rsp_err = 1'b1;
                    end
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over a timeout in the same cycle
                if (apb_master.pready) begin
                    w_state_nxt = IDLE;
                    w_rsp_vld   = 1'b1;
                    w_rsp_err   = apb_master.pslverr;
                    w_rsp_data  = r_we ? '0 : apb_master.prdata;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                    w_rsp_vld   = 1'b1;
                    w_rsp_err   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
            r_penable <= (w_state_nxt == ACCESS);
            r_rvalid  <= w_rsp_vld;
            r_err     <= w_rsp_err;
            r_rdata   <= w_rsp_data;
            if (w_gnt) begin
                r_addr  <= data_addr_i;
                r_wdata <= data_wdata_i;
                r_we    <= data_we_i;
            end
        end
    end

    assign data_gnt_o         = w_gnt;
    assign data_rvalid_o      = r_rvalid;
    assign data_err_o         = r_err;
    assign data_rdata_o       = r_rdata;

    assign apb_master.paddr   = r_addr;
    assign apb_master.pwdata  = r_wdata;
    assign apb_master.pwrite  = r_we;
    assign apb_master.psel    = r_psel;
    assign apb_master.penable = r_penable;

endmodule
`default_nettype wire
